// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared stopwatch state type, display record and timing constants
// Contents:
//   TICKS_PER_SEC : 50 ms ticks per second
//   SEC_MAX       : highest seconds value before carry into minutes
//   sw_state_t    : stopwatch control states
//   disp_t        : five BCD display digits, most significant first
package clock_pkg;

  localparam int TICKS_PER_SEC = 20;
  localparam int SEC_MAX       = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } disp_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - mod-MOD BCD digit with enable, clear and carry-out
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : synchronous clear, wins over en
//   en         : advance by one
//   digit      : current BCD value 0..MOD-1
//   carry      : high when en would roll the digit from MOD-1 back to 0
module bcd_digit_counter #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  assign carry = en && (digit == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      digit <= 4'd0;
    end else if (en) begin
      digit <= (digit == LAST) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_50ms.sv
// rtl/stopwatch_50ms.sv - 50 ms resolution stopwatch with run/pause/lap control
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   tick_50ms_in       : 50 ms square wave, rising edges advance the count
//   btn_start_stop     : single-cycle pulse, toggles run/pause (wins over lap_clear)
//   btn_lap_clear      : single-cycle pulse, lap freeze/release or clear when paused
//   disp_*             : BCD digits mm:ss.t, from the lap register while in LAP
//   running            : high in RUN and LAP
//   lap_frozen         : high in LAP
//   overflow           : one-cycle pulse when the count wraps to zero
module stopwatch_50ms #(
  parameter int TICKS_PER_SEC = clock_pkg::TICKS_PER_SEC,
  parameter int MIN_MAX       = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_50ms_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  output logic [3:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_tenths,
  output logic       running,
  output logic       lap_frozen,
  output logic       overflow
);

  import clock_pkg::*;

  localparam int              TICK_W       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam int              SEC_TENS_MOD = SEC_MAX / 10 + 1;
  localparam int              MIN_TENS_MOD = MIN_MAX / 10 + 1;
  localparam logic [3:0]      MIN_MAX_TENS = 4'(MIN_MAX / 10);
  localparam logic [3:0]      MIN_MAX_ONES = 4'(MIN_MAX % 10);

  sw_state_t         state, state_next;
  logic              latch_lap, clear_all;
  logic              tick_prev, tick, count_en;
  logic [TICK_W-1:0] tick_count;
  logic              tick_carry, sec_ones_carry, sec_carry, min_ones_carry, min_tens_carry;
  logic              min_is_max, wrap, min_clear, overflow_q;
  logic [3:0]        sec_ones, sec_tens, min_ones, min_tens, tenths_live;
  disp_t             live, lap_q, shown;

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_lap  = 1'b0;
    clear_all  = 1'b0;
    case (state)
      IDLE:  if (btn_start_stop) state_next = RUN;
      RUN: begin
        if (btn_start_stop) begin
          state_next = PAUSE;
        end else if (btn_lap_clear) begin
          state_next = LAP;
          latch_lap  = 1'b1;
        end
      end
      LAP: begin
        if (btn_start_stop)     state_next = PAUSE;
        else if (btn_lap_clear) state_next = RUN;
      end
      PAUSE: begin
        if (btn_start_stop) begin
          state_next = RUN;
        end else if (btn_lap_clear) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Rising-edge tick detect; counting uses the pre-transition state, so a
  // tick alongside start_stop counts only if we were already counting.
  always_ff @(posedge clk) begin
    if (reset) tick_prev <= 1'b0;
    else       tick_prev <= tick_50ms_in;
  end

  assign tick     = tick_50ms_in && !tick_prev;
  assign count_en = tick && ((state == RUN) || (state == LAP));

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      tick_count <= '0;
    end else if (count_en) begin
      tick_count <= (tick_count == TICK_LAST) ? '0 : tick_count + TICK_W'(1);
    end
  end

  assign tick_carry  = count_en && (tick_count == TICK_LAST);
  assign tenths_live = 4'(tick_count >> 1);

  bcd_digit_counter #(.MOD(10)) u_sec_ones (
    .clk(clk), .reset(reset), .clear(clear_all), .en(tick_carry),
    .digit(sec_ones), .carry(sec_ones_carry)
  );

  bcd_digit_counter #(.MOD(SEC_TENS_MOD)) u_sec_tens (
    .clk(clk), .reset(reset), .clear(clear_all), .en(sec_ones_carry),
    .digit(sec_tens), .carry(sec_carry)
  );

  // The tens carry only fires when MIN_MAX ends in 9 (where it coincides with
  // the explicit compare); otherwise that minute value is never reached.
  assign min_is_max = (min_tens == MIN_MAX_TENS) && (min_ones == MIN_MAX_ONES);
  assign wrap       = (sec_carry && min_is_max) || min_tens_carry;
  assign min_clear  = clear_all || wrap;

  bcd_digit_counter #(.MOD(10)) u_min_ones (
    .clk(clk), .reset(reset), .clear(min_clear), .en(sec_carry),
    .digit(min_ones), .carry(min_ones_carry)
  );

  bcd_digit_counter #(.MOD(MIN_TENS_MOD)) u_min_tens (
    .clk(clk), .reset(reset), .clear(min_clear), .en(min_ones_carry),
    .digit(min_tens), .carry(min_tens_carry)
  );

  // Registered alongside the counter clear so the pulse and the zero count
  // appear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= wrap;
  end

  assign live = {min_tens, min_ones, sec_tens, sec_ones, tenths_live};

  always_ff @(posedge clk) begin
    if (reset || clear_all) lap_q <= '0;
    else if (latch_lap)     lap_q <= live;
  end

  assign shown = (state == LAP) ? lap_q : live;

  // Outputs are forced low while reset is held, independent of register state.
  assign disp_min_tens = reset ? 4'd0 : shown.min_tens;
  assign disp_min_ones = reset ? 4'd0 : shown.min_ones;
  assign disp_sec_tens = reset ? 4'd0 : shown.sec_tens;
  assign disp_sec_ones = reset ? 4'd0 : shown.sec_ones;
  assign disp_tenths   = reset ? 4'd0 : shown.tenths;
  assign running       = !reset && ((state == RUN) || (state == LAP));
  assign lap_frozen    = !reset && (state == LAP);
  assign overflow      = !reset && overflow_q;

endmodule

// File: tb/tb_stopwatch_50ms.sv
// tb/tb_stopwatch_50ms.sv - directed self-checking bench for stopwatch_50ms
module tb_stopwatch_50ms;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Instance A: default parameters
  logic       reset, tick, ss, lc;
  logic [3:0] a_mt, a_mo, a_st, a_so, a_t;
  logic       a_run, a_lap, a_ovf;
  logic [19:0] a_disp;
  logic [2:0]  a_flags;

  // Instance B: MIN_MAX=1 so the wrap is reachable in a short run
  logic       reset_b, tick_b, ss_b, lc_b;
  logic [3:0] b_mt, b_mo, b_st, b_so, b_t;
  logic       b_run, b_lap, b_ovf;
  logic [19:0] b_disp;
  logic [2:0]  b_flags;

  assign a_disp  = {a_mt, a_mo, a_st, a_so, a_t};
  assign a_flags = {a_run, a_lap, a_ovf};
  assign b_disp  = {b_mt, b_mo, b_st, b_so, b_t};
  assign b_flags = {b_run, b_lap, b_ovf};

  stopwatch_50ms dut_a (
    .clk(clk), .reset(reset), .tick_50ms_in(tick),
    .btn_start_stop(ss), .btn_lap_clear(lc),
    .disp_min_tens(a_mt), .disp_min_ones(a_mo), .disp_sec_tens(a_st),
    .disp_sec_ones(a_so), .disp_tenths(a_t),
    .running(a_run), .lap_frozen(a_lap), .overflow(a_ovf)
  );

  stopwatch_50ms #(.TICKS_PER_SEC(20), .MIN_MAX(1)) dut_b (
    .clk(clk), .reset(reset_b), .tick_50ms_in(tick_b),
    .btn_start_stop(ss_b), .btn_lap_clear(lc_b),
    .disp_min_tens(b_mt), .disp_min_ones(b_mo), .disp_sec_tens(b_st),
    .disp_sec_ones(b_so), .disp_tenths(b_t),
    .running(b_run), .lap_frozen(b_lap), .overflow(b_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of tick, optionally with button pulses in the same cycle.
  task automatic tick_a(input logic with_ss, input logic with_lc);
    tick = 1'b1; ss = with_ss; lc = with_lc;
    step();
    tick = 1'b0; ss = 1'b0; lc = 1'b0;
    step();
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) tick_a(1'b0, 1'b0);
  endtask

  task automatic press_a(input logic p_ss, input logic p_lc);
    ss = p_ss; lc = p_lc;
    step();
    ss = 1'b0; lc = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ss = 1'b0; lc = 1'b0;
    reset_b = 1'b1; tick_b = 1'b0; ss_b = 1'b0; lc_b = 1'b0;
    step();
    step();
    check("reset_disp", a_disp, 20'h00000);
    check("reset_flags", a_flags, 3'b000);

    reset = 1'b0;
    step();
    check("idle_flags", a_flags, 3'b000);
    press_a(1'b0, 1'b1);
    check("idle_lap_ignored", a_flags, 3'b000);

    // start, 20 ticks -> one second
    press_a(1'b1, 1'b0);
    check("start_run", a_flags, 3'b100);
    ticks_a(20);
    check("one_second", a_disp, 20'h00010);
    check("one_second_flags", a_flags, 3'b100);

    // lap freeze at 00:03.4, live keeps counting
    ticks_a(48);
    check("at_3_4", a_disp, 20'h00034);
    press_a(1'b0, 1'b1);
    check("lap_flags", a_flags, 3'b110);
    ticks_a(10);
    check("lap_held", a_disp, 20'h00034);
    press_a(1'b0, 1'b1);
    check("lap_release", a_disp, 20'h00039);
    check("lap_release_flags", a_flags, 3'b100);

    // pause holds, clear returns to idle
    press_a(1'b1, 1'b0);
    check("pause_flags", a_flags, 3'b000);
    ticks_a(5);
    check("pause_hold", a_disp, 20'h00039);
    press_a(1'b0, 1'b1);
    check("clear_disp", a_disp, 20'h00000);
    check("clear_flags", a_flags, 3'b000);

    // tick with start in IDLE is not counted
    tick_a(1'b1, 1'b0);
    check("idle_coinc_run", a_flags, 3'b100);
    ticks_a(1);
    check("idle_coinc_count1", a_disp, 20'h00000);
    ticks_a(2);
    check("count3", a_disp, 20'h00001);

    // tick with both buttons in RUN: counted, PAUSE, no lap
    tick_a(1'b1, 1'b1);
    check("both_btn_counted", a_disp, 20'h00002);
    check("both_btn_pause", a_flags, 3'b000);

    // tick with start in PAUSE is not counted
    tick_a(1'b1, 1'b0);
    check("pause_coinc_run", a_flags, 3'b100);
    ticks_a(1);
    check("pause_coinc_count5", a_disp, 20'h00002);

    // tick with start in LAP is counted and display goes live
    press_a(1'b0, 1'b1);
    check("lap2_flags", a_flags, 3'b110);
    check("lap2_disp", a_disp, 20'h00002);
    tick_a(1'b1, 1'b0);
    check("lap_coinc_counted", a_disp, 20'h00003);
    check("lap_coinc_pause", a_flags, 3'b000);

    // long run to 12:34.5, then reset mid-count with tick held high
    press_a(1'b0, 1'b1);
    press_a(1'b1, 1'b0);
    ticks_a(15090);
    check("at_12_34_5", a_disp, 20'h12345);
    check("at_12_34_5_flags", a_flags, 3'b100);
    reset = 1'b1; tick = 1'b1;
    step();
    check("midreset_disp", a_disp, 20'h00000);
    check("midreset_flags", a_flags, 3'b000);
    reset = 1'b0; ss = 1'b1;
    step();
    ss = 1'b0;
    step();
    step();
    check("held_high_run", a_flags, 3'b100);
    check("held_high_no_count", a_disp, 20'h00000);
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    check("after_fall_rise_1", a_disp, 20'h00000);
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    check("after_fall_rise_2", a_disp, 20'h00001);
    tick = 1'b0;

    // wrap on instance B at 01:59.9
    reset_b = 1'b0;
    step();
    ss_b = 1'b1;
    step();
    ss_b = 1'b0;
    for (int i = 0; i < 2399; i++) begin
      tick_b = 1'b1;
      step();
      tick_b = 1'b0;
      step();
    end
    check("b_at_max", b_disp, 20'h01599);
    check("b_at_max_flags", b_flags, 3'b100);
    tick_b = 1'b1;
    step();
    check("b_wrap_disp", b_disp, 20'h00000);
    check("b_wrap_overflow", b_flags, 3'b101);
    tick_b = 1'b0;
    step();
    check("b_overflow_one_cycle", b_flags, 3'b100);
    check("b_after_wrap_disp", b_disp, 20'h00000);
    check("a_no_overflow", a_flags, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
